// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register model.
package i2c_target_pkg;

    // Bits per I2C byte, excluding the ACK bit.
    localparam int unsigned I2cBits = 8;

    // Counter width large enough to hold the value I2cBits.
    localparam int unsigned BitCntW = $clog2(I2cBits + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for asynchronous level inputs.
module prim_flop_2sync #(
    parameter int              Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage1;

    // Two back-to-back flops give metastability time to resolve.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage1 <= ResetValue;
            q_o    <= ResetValue;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values, forming a real 2-stage chain.
            stage1 <= d_i;
            q_o    <= stage1;
        end
    end

endmodule

// File: rtl/i2c_target_model.sv
// I2C target with a small byte-wide register file.
// A write transfer sets the register pointer with its first byte and
// then writes consecutive registers; a read transfer returns consecutive
// registers starting at the pointer. SCL is never stretched.
module i2c_target_model
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TargetAddr = 7'h50,
    parameter int         NumRegs    = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe_o,
    output logic busy_o
);

    localparam int unsigned PtrW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam logic [BitCntW-1:0] ByteDone = BitCntW'(I2cBits);

    // Synchronised bus levels and their previous samples.
    logic scl_s, sda_s;
    logic scl_q, sda_q;

    // Bus condition strobes, one clk_i cycle wide.
    logic start_det, stop_det, scl_rise, scl_fall;

    state_e              state;
    logic [BitCntW-1:0]  bit_cnt;
    logic [7:0]          shift;
    logic [PtrW-1:0]     ptr;
    logic                rw;
    logic                ptr_pending;
    logic [7:0]          regs [NumRegs];
    logic [7:0]          rd_byte;

    // Both bus lines reset to 1 so a reset never looks like a START or STOP.
    prim_flop_2sync #(
        .Width      (2),
        .ResetValue (2'b11)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({scl_i, sda_i}),
        .q_o    ({scl_s, sda_s})
    );

    // Previous-sample registers for edge and condition detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
    end

    // SDA moving while SCL stays high marks START/STOP; otherwise SCL edges clock data.
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;

    assign rd_byte = regs[ptr];

    // Transfer FSM, register file, pointer and registered bus outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            ptr_pending <= 1'b0;
            sda_oe_o    <= 1'b0;
            busy_o      <= 1'b0;
            // NOTE: the register file is visible state that must read 0 after reset, so it is reset like any other flop rather than left as an uninitialised RAM.
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (start_det) begin
            // A START or repeated START abandons any partial byte; the pointer is kept.
            state    <= ADDR;
            bit_cnt  <= '0;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b0;
        end else if (stop_det) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, IGNORE: begin
                    // Only a START leaves these states.
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift   <= {shift[6:0], sda_s};
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (scl_fall && bit_cnt == ByteDone) begin
                        if (shift[7:1] == TargetAddr) begin
                            state       <= ADDR_ACK;
                            rw          <= shift[0];
                            ptr_pending <= ~shift[0];
                            sda_oe_o    <= 1'b1;
                            busy_o      <= 1'b1;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt <= '0;
                        if (rw) begin
                            state    <= RD_DATA;
                            shift    <= rd_byte;
                            sda_oe_o <= ~rd_byte[7];
                        end else begin
                            state    <= WR_DATA;
                            sda_oe_o <= 1'b0;
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shift   <= {shift[6:0], sda_s};
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (scl_fall && bit_cnt == ByteDone) begin
                        // Commit only once all 8 bits are in, so partial bytes never write.
                        state    <= WR_ACK;
                        sda_oe_o <= 1'b1;
                        if (ptr_pending) begin
                            ptr         <= shift[PtrW-1:0];
                            ptr_pending <= 1'b0;
                        end else begin
                            regs[ptr] <= shift;
                            ptr       <= ptr + 1'b1;
                        end
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        state    <= WR_DATA;
                        bit_cnt  <= '0;
                        sda_oe_o <= 1'b0;
                    end
                end

                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt == ByteDone) begin
                            state    <= RD_ACK;
                            sda_oe_o <= 1'b0;
                            ptr      <= ptr + 1'b1;
                        end else begin
                            shift    <= {shift[6:0], 1'b0};
                            sda_oe_o <= ~shift[6];
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        // Master NACK ends the read; SDA is already released.
                        state <= IGNORE;
                    end else if (scl_fall) begin
                        state    <= RD_DATA;
                        bit_cnt  <= '0;
                        shift    <= rd_byte;
                        sda_oe_o <= ~rd_byte[7];
                    end
                end

                default: begin
                    state    <= IDLE;
                    sda_oe_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_model.sv
// Directed and randomized bus-level test of i2c_target_model against a
// transaction-level register model.
module tb_i2c_target_model;
    import i2c_target_pkg::*;

    localparam logic [6:0] TA = 7'h50;
    localparam int         NR = 16;
    localparam int         Q  = 10;   // clk_i cycles per SCL phase

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_oe;
    logic busy;
    logic sda_line;

    // Wired-AND bus: low if the master or the target pulls it down.
    assign sda_line = m_sda & ~sda_oe;

    i2c_target_model #(
        .TargetAddr (TA),
        .NumRegs    (NR)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .scl_i    (m_scl),
        .sda_i    (sda_line),
        .sda_oe_o (sda_oe),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    int         n_asserts = 0;
    int         n_fail    = 0;
    logic [7:0] m_regs [NR];
    int         m_ptr;
    logic [7:0] wbuf [8];
    logic [7:0] rbuf [4];
    logic       ack;
    logic       bitv;
    logic       watch_quiet = 1'b0;
    int         quiet_hits  = 0;
    int         hits0;
    int         n_rd;
    logic [6:0] rnd_addr;
    int         n_wr;

    // Counts any cycle where the target drives SDA or claims busy while it should be silent.
    always @(posedge clk) begin
        if (watch_quiet && (sda_oe || busy)) quiet_hits <= quiet_hits + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) check(tag, {24'h0, dut.regs[i]}, {24'h0, m_regs[i]});
        check({tag, "_ptr"}, 32'(dut.ptr), 32'(m_ptr));
    endtask

    // Works from an idle bus or as a repeated START with SCL low.
    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(3);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(Q);
        m_scl = 1'b0; tick(3);
    endtask

    task automatic read_bit(output logic v);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q / 2);
        v = sda_line; tick(Q / 2);
        m_scl = 1'b0; tick(3);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        logic v;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(v);
        a = ~v;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            d[i] = v;
        end
        write_bit(~mack);
    endtask

    // START, address+W, then n bytes from wbuf; no STOP.
    task automatic xfer_write(input logic [6:0] addr, input int n);
        logic a;
        logic match;
        match = (addr == TA);
        i2c_start();
        write_byte({addr, 1'b0}, a);
        check("wr_addr_ack", 32'(a), 32'(match));
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], a);
            check("wr_data_ack", 32'(a), 32'(match));
            if (match) begin
                if (i == 0) begin
                    m_ptr = wbuf[0] % NR;
                end else begin
                    m_regs[m_ptr] = wbuf[i];
                    m_ptr = (m_ptr + 1) % NR;
                end
            end
        end
    endtask

    // START, address+R, then n bytes (ACK all but the last); no STOP.
    task automatic xfer_read(input logic [6:0] addr, input int n);
        logic       a;
        logic       match;
        logic [7:0] d;
        logic [7:0] exp;
        match = (addr == TA);
        i2c_start();
        write_byte({addr, 1'b1}, a);
        check("rd_addr_ack", 32'(a), 32'(match));
        for (int i = 0; i < n; i++) begin
            exp = match ? m_regs[m_ptr] : 8'hFF;
            read_byte(d, i != n - 1);
            rbuf[i] = d;
            check("rd_data", {24'h0, d}, {24'h0, exp});
            if (match) m_ptr = (m_ptr + 1) % NR;
        end
        check("rd_release", 32'(sda_oe), 32'd0);
    endtask

    initial begin
        // Reset state
        model_reset();
        rst_n = 1'b0;
        tick(3);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check_regs("rst_regs");
        rst_n = 1'b1;
        tick(5);

        // Pointer 3, then two data bytes
        wbuf[0] = 8'h03; wbuf[1] = 8'hAA; wbuf[2] = 8'hBB;
        xfer_write(TA, 3);
        check("busy_in_xfer", 32'(busy), 32'd1);
        i2c_stop();
        check("busy_after_stop", 32'(busy), 32'd0);
        check("w_reg3", {24'h0, dut.regs[3]}, 32'h0000_00AA);
        check("w_reg4", {24'h0, dut.regs[4]}, 32'h0000_00BB);
        check("w_ptr", 32'(dut.ptr), 32'd5);

        // Set pointer, repeated START, read two bytes
        wbuf[0] = 8'h03;
        xfer_write(TA, 1);
        xfer_read(TA, 2);
        check("rs_byte0", {24'h0, rbuf[0]}, 32'h0000_00AA);
        check("rs_byte1", {24'h0, rbuf[1]}, 32'h0000_00BB);
        check("rs_nack_release", 32'(sda_oe), 32'd0);
        i2c_stop();

        // Foreign address: target stays silent
        hits0 = quiet_hits;
        watch_quiet = 1'b1;
        wbuf[0] = 8'h00; wbuf[1] = 8'h77; wbuf[2] = 8'h99;
        xfer_write(7'h51, 3);
        xfer_read(7'h51, 2);
        i2c_stop();
        watch_quiet = 1'b0;
        tick(1);
        check("foreign_quiet", 32'(quiet_hits - hits0), 32'd0);
        check_regs("foreign_regs");

        // Pointer wrap-around
        wbuf[0] = 8'h0F; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
        xfer_write(TA, 3);
        i2c_stop();
        check("wrap_reg15", {24'h0, dut.regs[15]}, 32'h0000_0011);
        check("wrap_reg0", {24'h0, dut.regs[0]}, 32'h0000_0022);
        check("wrap_ptr", 32'(dut.ptr), 32'd1);
        wbuf[0] = 8'h0F;
        xfer_write(TA, 1);
        xfer_read(TA, 2);
        check("wrap_rd0", {24'h0, rbuf[0]}, 32'h0000_0011);
        check("wrap_rd1", {24'h0, rbuf[1]}, 32'h0000_0022);
        i2c_stop();

        // STOP after 4 bits of a data byte
        i2c_start();
        write_byte({TA, 1'b0}, ack);
        check("part_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h06, ack);
        check("part_ptr_ack", 32'(ack), 32'd1);
        m_ptr = 6;
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        check("part_state", 32'(dut.state), 32'(IDLE));
        check("part_sda_oe", 32'(sda_oe), 32'd0);
        check("part_busy", 32'(busy), 32'd0);
        check_regs("part_regs");

        // Partial byte aborted by repeated START, then read at retained pointer
        i2c_start();
        write_byte({TA, 1'b0}, ack);
        write_byte(8'h08, ack);
        m_ptr = 8;
        for (int i = 0; i < 5; i++) write_bit(1'(i % 2));
        xfer_read(TA, 1);
        i2c_stop();
        check_regs("abort_regs");

        // Randomized transfers against the model
        for (int it = 0; it < 8; it++) begin
            rnd_addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : TA;
            n_wr = $urandom_range(1, 4);
            for (int k = 0; k < n_wr; k++) wbuf[k] = 8'($urandom);
            xfer_write(rnd_addr, n_wr);
            if ($urandom_range(0, 1) == 1) i2c_stop();
            wbuf[0] = 8'($urandom);
            xfer_write(TA, 1);
            n_rd = $urandom_range(1, 3);
            xfer_read(TA, n_rd);
            i2c_stop();
        end
        check_regs("rand_regs");

        // Reset while the target drives a 0 data bit
        wbuf[0] = 8'h07; wbuf[1] = 8'h12;
        xfer_write(TA, 2);
        i2c_stop();
        wbuf[0] = 8'h07;
        xfer_write(TA, 1);
        i2c_start();
        write_byte({TA, 1'b1}, ack);
        check("rst_rd_addr_ack", 32'(ack), 32'd1);
        read_bit(bitv);
        check("rst_rd_bit7", 32'(bitv), 32'd0);
        read_bit(bitv);
        check("rst_rd_bit6", 32'(bitv), 32'd0);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q / 2);
        check("pre_rst_sda_oe", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        model_reset();
        tick(1);
        check_regs("rst_mid_regs");
        rst_n = 1'b1;
        hits0 = quiet_hits;
        watch_quiet = 1'b1;
        tick(Q / 2);
        m_scl = 1'b0; tick(3);
        for (int i = 0; i < 5; i++) read_bit(bitv);
        write_bit(1'b0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        i2c_stop();
        watch_quiet = 1'b0;
        tick(1);
        check("post_rst_quiet", 32'(quiet_hits - hits0), 32'd0);

        // Normal operation after reset
        wbuf[0] = 8'h02; wbuf[1] = 8'hC3; wbuf[2] = 8'h3C;
        xfer_write(TA, 3);
        i2c_stop();
        wbuf[0] = 8'h02;
        xfer_write(TA, 1);
        xfer_read(TA, 2);
        i2c_stop();
        check_regs("post_rst_regs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target_model.md
I2C_TARGET_MODEL -- requirements
Module: i2c_target_model

Interface
REQ-001 SHALL have parameter TargetAddr, default 7'h50, the 7-bit bus address the block responds to.
REQ-002 SHALL have parameter NumRegs, default 16, the number of 8-bit registers (power of two, 2..256).
REQ-003 SHALL have port clk_i  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port scl_i  input  1  resolved I2C SCL line level (asynchronous).
REQ-006 SHALL have port sda_i  input  1  resolved I2C SDA line level (asynchronous).
REQ-007 SHALL have port sda_oe_o  output  1  when 1, the target pulls SDA low; when 0, SDA is released (open-drain).
REQ-008 SHALL have port busy_o  output  1  high from an address-matched START until the following STOP or START.

Function
REQ-009 SHALL pass scl_i and sda_i through 2-flop synchronisers; all edge and condition detection SHALL use the synchronised values, with previous-sample registers.
REQ-010 SHALL detect START or repeated START when SDA falls while SCL is high, and STOP when SDA rises while SCL is high; both SHALL take priority over any data-bit event in the same cycle.
REQ-011 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-012 SHALL enter ADDR on a START from any state, clear the bit counter, and sample one bit on each SCL rising edge, MSB first.
REQ-013 After 8 address bits, on a TargetAddr match, SHALL assert sda_oe_o within 2 clk_i cycles of the synchronised SCL falling edge, hold it through the 9th SCL high phase, and release it on the next SCL falling edge; on a mismatch SHALL go to IGNORE and never drive SDA.
REQ-014 In a write transfer (R/W=0), the first data byte SHALL load the register pointer modulo NumRegs; each later byte SHALL write reg[ptr], then increment ptr with wrap from NumRegs-1 to 0; every byte SHALL be ACKed.
REQ-015 In a read transfer (R/W=1), SHALL drive reg[ptr] MSB first, changing sda_oe_o only after a synchronised SCL falling edge (sda_oe_o = ~bit); after 8 bits SHALL release SDA, increment ptr with wrap, and sample the master ACK on the SCL rising edge.
REQ-016 A master ACK (SDA=0) SHALL continue with the next byte; a NACK SHALL go to IGNORE with SDA released.
REQ-017 A STOP SHALL return to IDLE, release SDA, and deassert busy_o within 1 cycle after detection; the pointer SHALL be retained.
REQ-018 A repeated START during any state SHALL abort the current byte without a register write, release SDA, and restart address reception; the pointer SHALL be retained, which allows write-pointer-then-read.
REQ-019 A partial byte, fewer than 8 bits before a START or STOP, SHALL NOT modify any register.
REQ-020 SHALL NOT stretch SCL; the block SHALL operate correctly for SCL periods of at least 8 clk_i cycles per phase.

Reset
REQ-021 On rst_ni low: state=IDLE, sda_oe_o=0, busy_o=0, ptr=0, all registers=8'h00, and synchronisers = 1 (idle bus).
REQ-022 An assertion of reset in the middle of a transfer SHALL release SDA immediately (asynchronously); after deassertion, the block SHALL ignore the bus until the next START.

Structure
REQ-023 Package i2c_target_pkg SHALL hold the state enum typedef and the I2C bit-count constant (8).
REQ-024 Synchronisers SHALL use the existing prim_flop_2sync sub-module; there SHALL be no other sub-module.
REQ-025 SHALL be instantiated once per I2C bus in the Verilator top, with sda_oe_o ANDed into the wired SDA resolution (the line is low if either side drives it).

Verification
REQ-026 Write to 0x50: bytes 0x03, 0xAA, 0xBB -> three data ACKs, and reg[3]=0xAA, reg[4]=0xBB, ptr=5.
REQ-027 Write 0x50 with 0x03, then a repeated START, then read 2 bytes with ACK then NACK -> returns 0xAA, 0xBB, SDA released after the NACK.
REQ-028 Address 0x51 with any traffic -> sda_oe_o stays 0 throughout, busy_o stays 0, and registers are unchanged.
REQ-029 Pointer 0x0F, write 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap-around).
REQ-030 Send a STOP after 4 bits of a data byte -> no register change, state IDLE, sda_oe_o=0.
REQ-031 Assert rst_ni while sda_oe_o=1 during a read -> sda_oe_o=0 in the same cycle, and registers = 0x00.
